// File: rtl/pdp8_bus_pkg.sv
// Shared PDP-8 nibble-bus definitions: bus codes, nibble indices, FSM states, word type.
// No logic; no latency; no backpressure.
package pdp8_bus_pkg;

    typedef logic [11:0] word_t;

    // Address codes compare against bus_out[7:6], the IO intro against bus_out[7:5]
    localparam logic [1:0] CODE_ADDR_HI  = 2'b10;
    localparam logic [1:0] CODE_ADDR_LO  = 2'b11;
    localparam logic [2:0] CODE_IO_INTRO = 3'b011;

    localparam logic [1:0] NIB_HI  = 2'b00;
    localparam logic [1:0] NIB_MID = 2'b01;
    localparam logic [1:0] NIB_LO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AH,
        ST_AL,
        ST_IOC,
        ST_DH,
        ST_DM
    } bus_state_e;

    function automatic logic [3:0] nibble_of(input word_t w, input logic [1:0] idx);
        case (idx)
            NIB_HI:  return w[11:8];
            NIB_MID: return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

endpackage

// File: rtl/pdp8_bus_if.sv
// CPU-facing nibble bus plus the simple external device port.
// No logic; no latency; no backpressure (the CPU never stalls).
interface pdp8_bus_if;
    import pdp8_bus_pkg::*;

    logic [7:0] bus_out;
    logic [3:0] bus_in;
    logic       io_strobe;
    logic [4:0] io_dev;
    logic       io_we;
    word_t      io_wdata;
    word_t      io_rdata;
    logic       io_ready;

    modport master (
        output bus_out, io_rdata, io_ready,
        input  bus_in, io_strobe, io_dev, io_we, io_wdata
    );

    modport slave (
        input  bus_out, io_rdata, io_ready,
        output bus_in, io_strobe, io_dev, io_we, io_wdata
    );

endinterface

// File: rtl/pdp8_bus_mem.sv
// 2**AW x 12-bit word store: combinational read port, synchronous write port.
// Read latency 0, write visible the cycle after; no backpressure.
module pdp8_bus_mem
    import pdp8_bus_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output word_t         rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata
);

    word_t mem [0:(1<<AW)-1];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/pdp8_bus_target.sv
// PDP-8 nibble-bus target: decodes CPU beats into memory or device transfers; PDP8_BUS_WPROT_EN write-protects words below WP_TOP.
// bus_in is combinational (0 cycles); commits land on the edge ending the lo beat; no backpressure.
module pdp8_bus_target
    import pdp8_bus_pkg::*;
#(
    parameter int    AW     = 8,
    parameter word_t WP_TOP = 12'h010
) (
    input  logic      clk,
    input  logic      reset,
    pdp8_bus_if.slave bus
);

`ifdef PDP8_BUS_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    bus_state_e state_q, state_d;
    logic [5:0] a_hi_q, a_hi_d;
    word_t      addr_q, addr_d;
    word_t      rdata_q, rdata_d;
    logic [7:0] wbuf_q, wbuf_d;
    logic       io_mode_q, io_mode_d;
    logic [4:0] io_dev_q, io_dev_d;
    word_t      io_wdata_q, io_wdata_d;
    logic       io_strobe_q, io_strobe_d;
    logic       io_we_q, io_we_d;

    logic       is_ahi, is_alo, is_intro, is_data;
    logic [1:0] nib_idx;
    logic       beat_w;
    word_t      commit_word;
    word_t      mem_rdata;
    logic       mem_we;
    logic       wp_hit;
    logic [3:0] bus_in_c;

    assign is_ahi      = (bus.bus_out[7:6] == CODE_ADDR_HI);
    assign is_alo      = (bus.bus_out[7:6] == CODE_ADDR_LO);
    assign is_intro    = (bus.bus_out[7:5] == CODE_IO_INTRO);
    assign is_data     = !bus.bus_out[7] && !is_intro;
    assign nib_idx     = bus.bus_out[6:5];
    assign beat_w      = bus.bus_out[4];
    assign commit_word = {wbuf_q, bus.bus_out[3:0]};
    assign wp_hit      = WPROT && (addr_q < WP_TOP);

    pdp8_bus_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .raddr (AW'({a_hi_q, bus.bus_out[5:0]})),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (AW'(addr_q)),
        .wdata (commit_word)
    );

    always_comb begin
        state_d     = state_q;
        a_hi_d      = a_hi_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        wbuf_d      = wbuf_q;
        io_mode_d   = io_mode_q;
        io_dev_d    = io_dev_q;
        io_wdata_d  = io_wdata_q;
        io_we_d     = io_we_q;
        io_strobe_d = 1'b0;
        mem_we      = 1'b0;

        // Address hi restarts from any state, abandoning whatever was in flight
        if (is_ahi) begin
            state_d = ST_AH;
            a_hi_d  = bus.bus_out[5:0];
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_AH: begin
                    if (is_alo) begin
                        state_d = ST_AL;
                        addr_d  = {a_hi_q, bus.bus_out[5:0]};
                        rdata_d = mem_rdata;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_AL, ST_IOC: begin
                    if (state_q == ST_AL && is_intro) begin
                        state_d   = ST_IOC;
                        io_dev_d  = bus.bus_out[4:0];
                        io_mode_d = 1'b1;
                        rdata_d   = bus.io_rdata;
                    end else if (is_data && nib_idx == NIB_HI) begin
                        state_d       = ST_DH;
                        wbuf_d[7:4]   = bus.bus_out[3:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DH: begin
                    if (is_data && nib_idx == NIB_MID) begin
                        state_d     = ST_DM;
                        wbuf_d[3:0] = bus.bus_out[3:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DM: begin
                    state_d = ST_IDLE;
                    if (is_data && nib_idx == NIB_LO) begin
                        if (io_mode_q) begin
                            io_strobe_d = 1'b1;
                            io_we_d     = beat_w;
                            if (beat_w) begin
                                io_wdata_d = commit_word;
                            end
                        end else begin
                            mem_we = beat_w && !wp_hit;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Device mode only survives while a transfer is still live
        if (state_d == ST_IDLE || state_d == ST_AH) begin
            io_mode_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_hi_q      <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            wbuf_q      <= '0;
            io_mode_q   <= 1'b0;
            io_dev_q    <= '0;
            io_wdata_q  <= '0;
            io_strobe_q <= 1'b0;
            io_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_hi_q      <= a_hi_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wbuf_q      <= wbuf_d;
            io_mode_q   <= io_mode_d;
            io_dev_q    <= io_dev_d;
            io_wdata_q  <= io_wdata_d;
            io_strobe_q <= io_strobe_d;
            io_we_q     <= io_we_d;
        end
    end

    // The CPU samples bus_in in the same cycle it drives the beat
    always_comb begin
        bus_in_c = 4'h0;
        if (is_intro) begin
            bus_in_c = {3'b000, bus.io_ready};
        end else if (is_data && !beat_w) begin
            bus_in_c = nibble_of(rdata_q, nib_idx);
        end
    end

    assign bus.bus_in    = bus_in_c;
    assign bus.io_strobe = io_strobe_q;
    assign bus.io_dev    = io_dev_q;
    assign bus.io_we     = io_we_q;
    assign bus.io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_pdp8_bus_target.sv
// Scoreboard bench for pdp8_bus_target: transaction-level memory/device model, per-beat bus_in queue, strobe queue.
module tb_pdp8_bus_target;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    pdp8_bus_if bif();

    pdp8_bus_target #(.AW(8), .WP_TOP(12'h010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: memory words keyed by aliased index (absent = never written)
    logic [11:0] mem_m [int];
    logic [4:0]  nib_q [$];   // {check, expected bus_in} per driven beat
    logic [17:0] stb_q [$];   // {we, dev, wdata} per expected device completion

    function automatic bit prot(input logic [11:0] a);
`ifdef PDP8_BUS_WPROT_EN
        return a < 12'h010;
`else
        return (a & 12'h000) != 12'h000;
`endif
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic beat(input logic [7:0] w, input bit chk, input logic [3:0] exp);
        @(posedge clk);
        #1;
        bif.bus_out = w;
        nib_q.push_back({chk, exp});
    endtask

    // cut: 0 full, 1 stop after hi data beat, 2 skip mid beat, 3 stop after mid beat
    task automatic xfer(input logic [11:0] addr, input bit io, input logic [4:0] dev,
                        input logic [11:0] word, input logic [2:0] w, input int cut,
                        input logic [11:0] iord, input bit iordy);
        logic [11:0] rd;
        bit known;
        int idx;
        idx = int'(addr[7:0]);
        beat({2'b10, addr[11:6]}, 1'b1, 4'h0);
        known = mem_m.exists(idx);
        rd = known ? mem_m[idx] : 12'h000;
        beat({2'b11, addr[5:0]}, 1'b1, 4'h0);
        if (io) begin
            bif.io_rdata = iord;
            bif.io_ready = iordy;
            rd = iord;
            known = 1'b1;
            beat({3'b011, dev}, 1'b1, {3'b000, iordy});
        end
        beat({3'b000, w[2], word[11:8]}, known || w[2], w[2] ? 4'h0 : rd[11:8]);
        bif.io_rdata = 12'($urandom);
        bif.io_ready = 1'($urandom);
        if (cut == 1) return;
        if (cut == 2) begin
            beat({3'b010, w[0], word[3:0]}, 1'b0, 4'h0);
            return;
        end
        beat({3'b001, w[1], word[7:4]}, known || w[1], w[1] ? 4'h0 : rd[7:4]);
        if (cut == 3) return;
        beat({3'b010, w[0], word[3:0]}, known || w[0], w[0] ? 4'h0 : rd[3:0]);
        if (io) begin
            stb_q.push_back({w[0], dev, w[0] ? word : 12'h000});
        end else if (w[0] && !prot(addr)) begin
            mem_m[idx] = word;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " io_strobe"}, {11'd0, bif.io_strobe}, 12'h000);
        check({tag, " io_we"},     {11'd0, bif.io_we},     12'h000);
        check({tag, " io_dev"},    {7'd0, bif.io_dev},     12'h000);
        check({tag, " io_wdata"},  bif.io_wdata,           12'h000);
        check({tag, " bus_in"},    {8'd0, bif.bus_in},     12'h000);
    endtask

    task automatic pulse_reset;
        @(posedge clk);
        #1;
        bif.bus_out = 8'h00;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
    endtask

    // Monitor: consumes one bus_in expectation per beat, one strobe entry per io_strobe pulse
    always @(negedge clk) begin
        logic [4:0]  e;
        logic [17:0] s;
        if (!reset) begin
            if (nib_q.size() > 0) begin
                e = nib_q.pop_front();
                if (e[4]) begin
                    vectors++;
                    if (bif.bus_in !== e[3:0]) begin
                        miscompares++;
                        $display("FAIL bus_in beat %h: got %h want %h", bif.bus_out, bif.bus_in, e[3:0]);
                    end
                end
            end
            if (bif.io_strobe === 1'b1) begin
                vectors++;
                if (stb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL io_strobe: got unexpected pulse want none");
                end else begin
                    s = stb_q.pop_front();
                    if (bif.io_we !== s[17] || bif.io_dev !== s[16:12] || (s[17] && bif.io_wdata !== s[11:0])) begin
                        miscompares++;
                        $display("FAIL io_strobe: got we=%b dev=%h wdata=%h want we=%b dev=%h wdata=%h",
                                 bif.io_we, bif.io_dev, bif.io_wdata, s[17], s[16:12], s[11:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bif.bus_out  = 8'h00;
        bif.io_rdata = 12'h000;
        bif.io_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        check_reset_outputs("reset");

        // Write 0xABC to 0x0C5 and read it back
        xfer(12'h0C5, 1'b0, 5'd0, 12'hABC, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h0C5, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        // Aliasing: bus address 0x1C5 lands on word 0xC5
        xfer(12'h1C5, 1'b0, 5'd0, 12'h123, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h0C5, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        // Device read of 0x7E1 from device 5 with ready high
        xfer(12'h0C0, 1'b1, 5'd5, 12'h000, 3'b000, 0, 12'h7E1, 1'b1);
        // Device write must leave memory untouched
        xfer(12'h0C0, 1'b0, 5'd0, 12'h321, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h0C0, 1'b1, 5'd2, 12'h456, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h0C0, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        // Address hi after the hi data beat abandons the write; next read proves AH restart
        xfer(12'h0C5, 1'b0, 5'd0, 12'h777, 3'b111, 1, 12'h000, 1'b0);
        xfer(12'h0C5, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        // Reset between mid and lo beats: nothing commits, outputs back to reset values
        xfer(12'h0C5, 1'b1, 5'd9, 12'h999, 3'b111, 3, 12'h000, 1'b1);
        pulse_reset();
        check_reset_outputs("midreset");
        beat(8'h59, 1'b1, 4'h0);
        xfer(12'h0C5, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        // Protection boundary: 0x10F aliases 0x0F but is above WP_TOP
        xfer(12'h10F, 1'b0, 5'd0, 12'h5A5, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h00F, 1'b0, 5'd0, 12'hFFF, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h00F, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);
        xfer(12'h010, 1'b0, 5'd0, 12'hFFF, 3'b111, 0, 12'h000, 1'b0);
        xfer(12'h010, 1'b0, 5'd0, 12'h000, 3'b000, 0, 12'h000, 1'b0);

        for (int t = 0; t < 300; t++) begin
            logic [11:0] a;
            logic [2:0]  w;
            int          cut;
            bit          io;
            a   = {2'($urandom), 7'd0, 3'($urandom)};
            io  = ($urandom_range(0, 3) == 0);
            w   = 3'($urandom);
            if ($urandom_range(0, 2) == 0) w = 3'b000;
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            xfer(a, io, 5'($urandom), 12'($urandom), w, cut, 12'($urandom), 1'($urandom));
        end

        repeat (3) beat(8'h00, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("beat queue drained", 12'(nib_q.size()), 12'h000);
        check("strobe queue drained", 12'(stb_q.size()), 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pdp8_bus_target.md
Name: pdp8_bus_target

Overview:
Bus-side target for the moonbase PDP-8 nibble bus. It decodes the CPU's 8-bit output stream (address beats, IO intro, read/write data nibbles) and answers read nibbles and IO-ready on the CPU's 4-bit data input.
- Memory beats hit an internal 12-bit word memory.
- Beats preceded by an IO intro are routed to a simple external device port.
- Sits directly downstream of the CPU core: cpu io_out -> bus_out, bus_in -> cpu io_in[7:4].

Parameters:
AW, 8, memory address width; depth = 2**AW words of 12 bits; bus address bits above AW are ignored, so memory aliases.
WP_TOP, 12'h010, words 0..WP_TOP-1 are write-protected; used only with the optional feature.

Ports:
clk  in  1  single clock; all state on rising edge.
reset  in  1  asynchronous, active-high.
bus_out  in  8  CPU bus word.
bus_in  out  4  nibble returned to CPU (cpu io_in[7:4]).
io_strobe  out  1  one-cycle pulse when a device transfer completes.
io_dev  out  5  device code latched from the IO intro.
io_we  out  1  qualifies io_strobe as a write.
io_wdata  out  12  assembled write word to the device.
io_rdata  in  12  device read word; sampled on the IO intro cycle.
io_ready  in  1  device ready; returned combinationally on bus_in[0] during the IO intro.

Behaviour:
- Bus decode of bus_out[7:5]:
  - 1 0 x: address hi; latch a_hi = bus_out[5:0].
  - 1 1 x: address lo; address = {a_hi, bus_out[5:0]}.
  - 0 1 1: IO intro; latch io_dev = bus_out[4:0] and set io_mode.
  - otherwise: data beat. Nibble index = bus_out[6:5] (00 hi, 01 mid, 10 lo); W = bus_out[4]; D = bus_out[3:0].
- FSM states and transitions:
  - IDLE -> AH on address hi.
  - AH -> AL on address lo. Any other word in AH returns to IDLE with no action.
  - AL -> IOC on IO intro; AL -> DH on a hi data beat.
  - IOC -> DH on a hi data beat.
  - DH -> DM on a mid beat; DM -> IDLE on a lo beat.
  - An address-hi word in any state restarts at AH and abandons the current transfer.
  - An out-of-order nibble index returns to IDLE with no commit.
- Memory read: on the address-lo cycle, rdata <= mem[address[AW-1:0]] (combinational array read, registered result). On IO intro, rdata <= io_rdata.
- bus_in (combinational, zero latency, because the CPU samples it in the same cycle):
  - Read data beat: nibble of rdata chosen by index.
  - IO intro: {3'b000, io_ready}.
  - Otherwise: 4'h0.
- Write: wbuf[11:8] loads on hi beat, wbuf[7:4] on mid beat. On the lo beat with W = 1:
  - Memory mode: mem[addr] <= {wbuf[11:4], D}.
  - io_mode: io_wdata <= the same word, io_we = 1, io_strobe pulses for one cycle.
- Read completion in io_mode: io_strobe pulses on the lo beat with io_we = 0.
- io_mode clears on commit and on any abort.
- Mixed W within one transfer: the W bit of the lo beat decides.
- Reset values: state = IDLE, a_hi = 0, rdata = 0, wbuf = 0, io_mode = 0, io_dev = 0, io_wdata = 0, io_strobe = 0, io_we = 0. Memory contents are not reset.
- Reset asserted mid-transfer: transfer dropped, no commit.
- Latency: write visible to a read whose address-lo beat falls at least one cycle after the commit cycle.

Optional Feature:
PDP8_BUS_WPROT_EN:
- Defined: memory writes with address < WP_TOP are silently dropped. Reads are unaffected. Device writes are unaffected.
- Undefined: all memory writes commit; WP_TOP is unused.

Decomposition:
- Package pdp8_bus_pkg holds the following, shared with the CPU and benches:
  - bus code constants (ADDR_HI, ADDR_LO, IO_INTRO, nibble index values);
  - FSM state enum;
  - the 12-bit word typedef.
- One sub-module, pdp8_bus_mem: 2**AW x 12 array with combinational read port and synchronous write port.

Test Plan:
- Write then read back: 0x83,0xC5 (addr 0x0C5); 0x1A,0x3B,0x5C commits 0xABC. Then 0x83,0xC5,0x00,0x20,0x40 -> bus_in A, B, C on the three data cycles.
- Alias: AW = 8. Write 0x123 to bus addr 0x1C5, read addr 0x0C5 -> 0x123.
- IO intro 0x65 with io_ready = 1, io_rdata = 0x7E1:
  - bus_in = 0x1 on the intro cycle;
  - read beats return 7, E, 1;
  - io_strobe pulses once, io_we = 0, io_dev = 5.
- IO write: 0x83,0xC0,0x62 then write beats 0x14,0x35,0x56 -> io_wdata = 0x456, io_we = 1, one-cycle io_strobe, memory unchanged.
- Abort/reset:
  - address hi injected after the hi data beat -> no commit, FSM back in AH;
  - reset pulsed between mid and lo beats -> no commit, all outputs at reset values.
- With PDP8_BUS_WPROT_EN: write 0xFFF to addr 0x00F -> readback unchanged. Write to addr 0x010 -> readback 0xFFF.
